// File: rtl/rst_seq.sv
// Reset sequencer: synchronises the board reset, then releases core, codec and
// datapath resets in order with programmable dwell times. sw_rst restarts the sequence.
module rst_seq #(
  parameter int unsigned HOLD_CYC   = 16,
  parameter int unsigned CODEC_HOLD = 1024,
  parameter int unsigned CODEC_WAKE = 2048,
  parameter int unsigned CNT_W      = 16
) (
  input  logic clk,
  input  logic RST_n,
  input  logic sw_rst,
  output logic core_rst_n,
  output logic codec_rst_n,
  output logic dp_rst_n,
  output logic seq_done,
  output logic busy
);

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_CORE = 2'd1;
  localparam logic [1:0] S_WAKE = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  // Terminal counts: a transition fires on the edge where cnt == N-1.
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CORE_LAST  = CNT_W'(CODEC_HOLD - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(CODEC_WAKE - 1);

  logic             sync1_q, rel_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_q, codec_q, dp_q, done_q;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      sync1_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= 1'b1;
      rel_q   <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_HOLD: begin
        if (!rel_q) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_CORE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CORE: begin
        if (cnt_q == CORE_LAST) begin
          state_d = S_WAKE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase
    // Software reset overrides any dwell transition on the same edge.
    if (sw_rst) begin
      state_d = S_HOLD;
      cnt_d   = '0;
    end
  end

  // Outputs decode the next state so they change on the transition edge itself.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      core_q  <= 1'b0;
      codec_q <= 1'b0;
      dp_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      core_q  <= (state_d != S_HOLD);
      codec_q <= (state_d == S_WAKE) || (state_d == S_RUN);
      dp_q    <= (state_d == S_RUN);
      done_q  <= (state_d == S_RUN);
    end
  end

  assign core_rst_n  = core_q;
  assign codec_rst_n = codec_q;
  assign dp_rst_n    = dp_q;
  assign seq_done    = done_q;
  assign busy        = ~done_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: power-on schedule, async reset, software reset
// pulse/hold, sw_rst on a transition edge, and minimum-dwell instance.
module tb_rst_seq;

  logic clk    = 1'b0;
  logic clk_en = 1'b1;
  logic RST_n  = 1'b0;
  logic sw_rst = 1'b0;

  logic d_core, d_codec, d_dp, d_done, d_busy;
  logic m_core, m_codec, m_dp, m_done, m_busy;

  rst_seq u_dut (
    .clk(clk), .RST_n(RST_n), .sw_rst(sw_rst),
    .core_rst_n(d_core), .codec_rst_n(d_codec), .dp_rst_n(d_dp),
    .seq_done(d_done), .busy(d_busy)
  );

  rst_seq #(.HOLD_CYC(1), .CODEC_HOLD(1), .CODEC_WAKE(1)) u_min (
    .clk(clk), .RST_n(RST_n), .sw_rst(sw_rst),
    .core_rst_n(m_core), .codec_rst_n(m_codec), .dp_rst_n(m_dp),
    .seq_done(m_done), .busy(m_busy)
  );

  always #5 if (clk_en) clk = ~clk;

  typedef struct { int off; logic [4:0] exp; } vec_t;
  vec_t sched[6];
  vec_t mins[5];

  int e = -1;
  int errors = 0;
  int checks = 0;
  int bad = 0;
  int tc, tk, td;
  int m, k2, k3;

  function automatic logic [4:0] dflt();
    return {d_core, d_codec, d_dp, d_done, d_busy};
  endfunction

  function automatic logic [4:0] mini();
    return {m_core, m_codec, m_dp, m_done, m_busy};
  endfunction

  task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%b required=%b", nm, e, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0d required=%0d", nm, e, got, exp);
    end
  endtask

  task automatic set_base(input int base);
    tc = base + 16;
    tk = base + 1040;
    td = base + 3088;
  endtask

  // One rising edge; every cycle is compared against the release thresholds.
  task automatic step();
    logic [4:0] x;
    @(posedge clk);
    #1;
    e++;
    x = {e >= tc, e >= tk, e >= td, e >= td, e < td};
    if (dflt() !== x) bad++;
  endtask

  task automatic walk(input int upto);
    while (e < upto) step();
  endtask

  task automatic run_sched(input string nm, input int base);
    for (int unsigned i = 0; i < 6; i++) begin
      walk(base + sched[i].off);
      chk(nm, dflt(), sched[i].exp);
    end
  endtask

  task automatic glitch(input string nm);
    chk_int(nm, bad, 0);
    bad = 0;
  endtask

  initial begin
    // Offsets from the edge after which rel is high (base); {core,codec,dp,done,busy}.
    sched[0] = '{15,   5'b00001};
    sched[1] = '{16,   5'b10001};
    sched[2] = '{1039, 5'b10001};
    sched[3] = '{1040, 5'b11001};
    sched[4] = '{3087, 5'b11001};
    sched[5] = '{3088, 5'b11110};
    mins[0]  = '{0, 5'b00001};
    mins[1]  = '{1, 5'b00001};
    mins[2]  = '{2, 5'b10001};
    mins[3]  = '{3, 5'b11001};
    mins[4]  = '{4, 5'b11110};

    // Power-on: RST_n low across three edges, released in the low phase.
    set_base(1);
    #31;
    chk("reset_state", dflt(), 5'b00001);
    chk("reset_state_min", mini(), 5'b00001);
    #1 RST_n = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      chk("min_dwell", mini(), mins[i].exp);
    end
    run_sched("poweron", 1);
    glitch("poweron_no_toggle");

    // Async assert in RUN with the clock stopped, pulse shorter than a period.
    clk_en = 1'b0;
    #2 RST_n = 1'b0;
    #1;
    chk("async_run", dflt(), 5'b00001);
    chk("async_run_min", mini(), 5'b00001);
    #1 RST_n = 1'b1;
    #1;
    chk("async_after_rise", dflt(), 5'b00001);
    #10 clk_en = 1'b1;
    e = -1;
    set_base(1);
    walk(16);
    chk("rerel_core_pre", dflt(), 5'b00001);
    walk(17);
    chk("rerel_core", dflt(), 5'b10001);
    walk(1100);
    chk("rerel_wake", dflt(), 5'b11001);
    glitch("rerel_no_toggle");

    // sw_rst held for 50 edges during WAKE.
    tc = 1000000000; tk = 1000000000; td = 1000000000;
    sw_rst = 1'b1;
    repeat (50) step();
    m = e;
    sw_rst = 1'b0;
    chk("swhold_low", dflt(), 5'b00001);
    glitch("swhold_outputs_low");
    set_base(m);
    walk(m + 15);
    chk("swhold_core_pre", dflt(), 5'b00001);
    walk(m + 16);
    chk("swhold_core", dflt(), 5'b10001);
    walk(m + 1039);
    chk("pre_simul", dflt(), 5'b10001);

    // sw_rst on the edge where CORE->WAKE would fire.
    k2 = e + 1;
    set_base(k2);
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    chk("simul_hold", dflt(), 5'b00001);
    run_sched("after_simul", k2);
    glitch("simul_no_codec_pulse");

    // One-cycle sw_rst pulse in RUN.
    k3 = e + 1;
    set_base(k3);
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    chk("swpulse_low", dflt(), 5'b00001);
    run_sched("swpulse", k3);
    glitch("swpulse_no_toggle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
